// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the iterative binary-to-BCD converter.
// Rev 1.0
`default_nettype none

package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [31:0] max_dec(input int digits);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < digits; i++) begin
      r = r * 32'd10;
    end
    return r - 32'd1;
  endfunction

  // Bit counter width needed to hold the value in_width.
  function automatic int cnt_width(input int in_width);
    return $clog2(in_width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to digits of 5 or more.
// Rev 1.0
`default_nettype none

module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock binary-to-BCD converter with overflow
// saturation and leading-zero blanking. Rev 1.0
`default_nettype none

module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   binary_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int                CW        = cnt_width(IN_WIDTH);
  localparam int                AW        = 4 * DIGITS + 4;
  localparam logic [31:0]       MAX_VAL   = max_dec(DIGITS);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t              state;
  logic [IN_WIDTH-1:0] sreg;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_adj;
  logic [AW-1:0]       acc_next;
  logic [CW-1:0]       cnt;
  logic                ovf_pend;
  logic [DIGITS-1:0]   blank_next;
  logic                zero_run;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  assign acc_next = {acc_adj[AW-2:0], sreg[IN_WIDTH-1]};

  // Walk from the most significant digit down; a digit blanks only while every
  // digit above it is also zero. Digit 0 never blanks.
  always_comb begin
    blank_next = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run & (acc_next[4*k +: 4] == 4'd0);
      blank_next[k] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      blank    <= BLANK_RST;
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= binary_in;
            acc      <= '0;
            cnt      <= CW'(IN_WIDTH);
            ovf_pend <= (32'(binary_in) > MAX_VAL);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc  <= acc_next;
          sreg <= sreg << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
            overflow <= ovf_pend;
            if (ovf_pend) begin
              bcd_out <= {DIGITS{4'h9}};
              blank   <= '0;
            end else begin
              bcd_out <= acc_next[4*DIGITS-1:0];
              blank   <= blank_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vector bench for three converter configurations.
// Rev 1.0
`default_nettype none

module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // (8,3) default instance
  logic        start1 = 1'b0;
  logic [7:0]  bin1   = '0;
  logic        busy1, done1, ovf1;
  logic [11:0] bcd1;
  logic [2:0]  blank1;

  // (8,2) overflow instance
  logic        start2 = 1'b0;
  logic [7:0]  bin2   = '0;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [1:0]  blank2;

  // (1,1) degenerate instance
  logic        start3 = 1'b0;
  logic [0:0]  bin3   = '0;
  logic        busy3, done3, ovf3;
  logic [3:0]  bcd3;
  logic [0:0]  blank3;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .binary_in(bin1),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1), .blank(blank1)
  );

  bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .binary_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2), .blank(blank2)
  );

  bin_to_bcd_seq #(.IN_WIDTH(1), .DIGITS(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .binary_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3), .blank(blank3)
  );

  typedef struct {
    logic [7:0]  v;
    logic [11:0] bcd;
    logic [2:0]  blank;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sel_done(input int which);
    return (which == 1) ? done1 : (which == 2) ? done2 : done3;
  endfunction

  function automatic logic sel_busy(input int which);
    return (which == 1) ? busy1 : (which == 2) ? busy2 : busy3;
  endfunction

  // Drive start for one cycle on the chosen instance.
  task automatic pulse(input int which, input logic [7:0] v);
    @(negedge clk);
    case (which)
      1: begin start1 = 1'b1; bin1 = v; end
      2: begin start2 = 1'b1; bin2 = v; end
      default: begin start3 = 1'b1; bin3 = v[0]; end
    endcase
  endtask

  // Count edges (from the start edge) until done; bounded.
  task automatic wait_done(input int which, output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      edges++;
      if (sel_busy(which)) busy_cnt++;
    end while (!sel_done(which) && edges < 40);
  endtask

  initial begin
    int edges, bcnt, ndone;

    tbl[0] = '{8'd0,   12'h000, 3'b110};
    tbl[1] = '{8'd255, 12'h255, 3'b000};
    tbl[2] = '{8'd7,   12'h007, 3'b110};
    tbl[3] = '{8'd100, 12'h100, 3'b000};
    tbl[4] = '{8'd99,  12'h099, 3'b100};
    tbl[5] = '{8'd10,  12'h010, 3'b100};
    tbl[6] = '{8'd1,   12'h001, 3'b110};
    tbl[7] = '{8'd128, 12'h128, 3'b000};
    tbl[8] = '{8'd9,   12'h009, 3'b110};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  32'(busy1),  32'h0);
    check("rst_done",  32'(done1),  32'h0);
    check("rst_bcd",   32'(bcd1),   32'h0);
    check("rst_ovf",   32'(ovf1),   32'h0);
    check("rst_blank", 32'(blank1), 32'h6);
    check("rst_blank2", 32'(blank2), 32'h2);

    for (int i = 0; i < 9; i++) begin
      pulse(1, tbl[i].v);
      wait_done(1, edges, bcnt);
      check($sformatf("lat_%0d", tbl[i].v),   32'(edges),  32'd9);
      check($sformatf("busy_%0d", tbl[i].v),  32'(bcnt),   32'd8);
      check($sformatf("bcd_%0d", tbl[i].v),   32'(bcd1),   32'(tbl[i].bcd));
      check($sformatf("blank_%0d", tbl[i].v), 32'(blank1), 32'(tbl[i].blank));
      check($sformatf("ovf_%0d", tbl[i].v),   32'(ovf1),   32'h0);
      @(negedge clk);
      check($sformatf("pulse_%0d", tbl[i].v), 32'(done1),  32'h0);
      check($sformatf("hold_%0d", tbl[i].v),  32'(bcd1),   32'(tbl[i].bcd));
    end

    // Back-to-back: second start raised in the done cycle.
    pulse(1, 8'd7);
    wait_done(1, edges, bcnt);
    check("b2b_bcd_a",   32'(bcd1),   32'h007);
    check("b2b_blank_a", 32'(blank1), 32'h6);
    start1 = 1'b1;
    bin1   = 8'd100;
    wait_done(1, edges, bcnt);
    check("b2b_gap",     32'(edges),  32'd9);
    check("b2b_bcd_b",   32'(bcd1),   32'h100);
    check("b2b_blank_b", 32'(blank1), 32'h0);

    // start held every cycle, input scrambled mid-conversion.
    pulse(1, 8'd37);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (ndone == 1) check("busy_start_bcd", 32'(bcd1), 32'h037);
        start1 = 1'b0;
      end else if (ndone == 0) begin
        start1 = 1'b1;
        bin1   = 8'(c * 13 + 200);
      end
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);

    // Reset partway through a conversion.
    pulse(1, 8'd200);
    repeat (4) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",  32'(busy1),  32'h0);
    check("mid_rst_bcd",   32'(bcd1),   32'h0);
    check("mid_rst_ovf",   32'(ovf1),   32'h0);
    check("mid_rst_blank", 32'(blank1), 32'h6);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("mid_rst_nodone", 32'(ndone), 32'd0);
    pulse(1, 8'd10);
    wait_done(1, edges, bcnt);
    check("after_rst_bcd",   32'(bcd1),   32'h010);
    check("after_rst_blank", 32'(blank1), 32'h4);

    // Two-digit instance: overflow boundary.
    pulse(2, 8'd150);
    wait_done(2, edges, bcnt);
    check("d2_150_lat",   32'(edges),  32'd9);
    check("d2_150_ovf",   32'(ovf2),   32'h1);
    check("d2_150_bcd",   32'(bcd2),   32'h99);
    check("d2_150_blank", 32'(blank2), 32'h0);
    pulse(2, 8'd42);
    wait_done(2, edges, bcnt);
    check("d2_42_ovf",    32'(ovf2),   32'h0);
    check("d2_42_bcd",    32'(bcd2),   32'h42);
    check("d2_42_blank",  32'(blank2), 32'h0);
    pulse(2, 8'd99);
    wait_done(2, edges, bcnt);
    check("d2_99_ovf",    32'(ovf2),   32'h0);
    check("d2_99_bcd",    32'(bcd2),   32'h99);
    pulse(2, 8'd100);
    wait_done(2, edges, bcnt);
    check("d2_100_ovf",   32'(ovf2),   32'h1);
    check("d2_100_bcd",   32'(bcd2),   32'h99);
    pulse(2, 8'd9);
    wait_done(2, edges, bcnt);
    check("d2_9_ovf",     32'(ovf2),   32'h0);
    check("d2_9_bcd",     32'(bcd2),   32'h09);
    check("d2_9_blank",   32'(blank2), 32'h2);

    // One-bit instance: two-edge conversion.
    pulse(3, 8'd1);
    wait_done(3, edges, bcnt);
    check("w1_lat",   32'(edges),  32'd2);
    check("w1_busy",  32'(bcnt),   32'd1);
    check("w1_bcd",   32'(bcd3),   32'h1);
    check("w1_blank", 32'(blank3), 32'h0);
    check("w1_ovf",   32'(ovf3),   32'h0);
    @(negedge clk);
    check("w1_pulse", 32'(done3),  32'h0);
    pulse(3, 8'd0);
    wait_done(3, edges, bcnt);
    check("w1_zero_lat", 32'(edges), 32'd2);
    check("w1_zero_bcd", 32'(bcd3),  32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire
